// File: rtl/riscv_structures.sv
// Shared front-end definitions.
//   REG_AW     : architectural register address width
//   hz_state_e : hazard controller sequencing states
package riscv_structures;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
//   clk   : clock
//   clr_n : asynchronous active-low clear
//   inc   : count this cycle
//   count : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Fetch/decode sequencing controller: load-use stalls, redirect squash
// windows and data-memory freeze, with saturating stall/flush counters.
//   clk, reset_n            : clock, async active-low reset
//   de_*                    : instruction entering decode (valid, sources)
//   ex_*                    : instruction in execute (valid, rd, load, writes)
//   br_taken                : redirect resolved in execute this cycle
//   mem_busy                : data memory not ready, freeze front end
//   fe_en / de_en / de_pc_r : fetch enable, decode enable, decode squash
//   stall_cnt / flush_cnt   : saturating performance counters
module hazard_ctrl
    import riscv_structures::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_uses_rs1,
    input  logic              de_uses_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic              fe_en,
    output logic              de_en,
    output logic              de_pc_r,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [2:0] LU_REM = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FL_REM = 3'(FLUSH_CYCLES - 1);

    hz_state_e  state, state_nxt;
    logic [2:0] rem, rem_nxt;
    logic       lu_hit;
    logic       fe_c, de_c, pr_c;
    logic       stall_inc, flush_inc;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu_hit = de_valid & ex_valid & ex_mem_read & ex_reg_write &
                    (ex_rd != '0) &
                    ((de_uses_rs1 & (de_rs1 == ex_rd)) |
                     (de_uses_rs2 & (de_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        fe_c      = 1'b1;
        de_c      = 1'b1;
        pr_c      = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (mem_busy) begin
            // Freeze everything; execute keeps br_taken/load until released.
            fe_c = 1'b0;
            de_c = 1'b0;
        end else if (br_taken) begin
            // Redirect wins over any stall and restarts the squash window.
            pr_c      = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                rem_nxt   = FL_REM;
            end else begin
                state_nxt = RUN;
                rem_nxt   = '0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (lu_hit) begin
                        // Hold decode, push a bubble into execute.
                        fe_c      = 1'b0;
                        pr_c      = 1'b1;
                        stall_inc = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = LU_STALL;
                            rem_nxt   = LU_REM;
                        end
                    end
                end
                LU_STALL: begin
                    fe_c      = 1'b0;
                    pr_c      = 1'b1;
                    stall_inc = 1'b1;
                    rem_nxt   = rem - 3'd1;
                    if (rem == 3'd1) state_nxt = RUN;
                end
                FLUSH: begin
                    pr_c      = 1'b1;
                    flush_inc = 1'b1;
                    rem_nxt   = rem - 3'd1;
                    if (rem == 3'd1) state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                    rem_nxt   = '0;
                end
            endcase
        end
    end

    // While in reset the front end is held with a squashed decode entry.
    assign fe_en   = reset_n & fe_c;
    assign de_en   = reset_n & de_c;
    assign de_pc_r = ~reset_n | pr_c;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (reset_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=1/CNT_W=32 and
// LOAD_LAT=3/CNT_W=4) share stimulus; each is tracked by a remaining-cycles
// reference model. Directed sequences, a vector table, then random traffic.
module tb_hazard_ctrl;

    typedef struct {
        logic       de_valid;
        logic [4:0] rs1, rs2;
        logic       u1, u2, ex_valid;
        logic [4:0] rd;
        logic       mr, rw, br, busy;
    } in_t;

    typedef struct {
        string name;
        in_t   in;
        logic  fe, de, pr;
    } vec_t;

    logic       clk, reset_n;
    logic       de_valid, de_uses_rs1, de_uses_rs2, ex_valid, ex_mem_read, ex_reg_write;
    logic       br_taken, mem_busy;
    logic [4:0] de_rs1, de_rs2, ex_rd;
    logic       fe_a, de_a, pr_a, fe_b, de_b, pr_b;
    logic [31:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state: remaining squash / stall cycles and counters
    int     m_sl[2], m_fl[2];
    longint m_sc[2], m_fc[2];
    int     lat[2]  = '{1, 3};
    longint cmax[2] = '{64'hFFFF_FFFF, 15};
    localparam int FLC = 2;

    hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(FLC), .CNT_W(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .de_valid(de_valid), .de_rs1(de_rs1),
        .de_rs2(de_rs2), .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .br_taken(br_taken), .mem_busy(mem_busy),
        .fe_en(fe_a), .de_en(de_a), .de_pc_r(pr_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(FLC), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .de_valid(de_valid), .de_rs1(de_rs1),
        .de_rs2(de_rs2), .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .br_taken(br_taken), .mem_busy(mem_busy),
        .fe_en(fe_b), .de_en(de_b), .de_pc_r(pr_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(logic dv, logic [4:0] r1, logic [4:0] r2, logic a1, logic a2,
                               logic ev, logic [4:0] rd, logic mr, logic rw, logic br, logic bz);
        in_t v;
        v.de_valid = dv; v.rs1 = r1; v.rs2 = r2; v.u1 = a1; v.u2 = a2;
        v.ex_valid = ev; v.rd = rd; v.mr = mr; v.rw = rw; v.br = br; v.busy = bz;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(in_t v);
        de_valid = v.de_valid; de_rs1 = v.rs1; de_rs2 = v.rs2;
        de_uses_rs1 = v.u1; de_uses_rs2 = v.u2; ex_valid = v.ex_valid;
        ex_rd = v.rd; ex_mem_read = v.mr; ex_reg_write = v.rw;
        br_taken = v.br; mem_busy = v.busy;
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sl[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    // Check one instance against the model for the current cycle, then advance.
    task automatic model_cycle(int k);
        logic  e_fe, e_de, e_pr, lu;
        string p;
        p = (k == 0) ? "a" : "b";
        lu = de_valid && ex_valid && ex_mem_read && ex_reg_write && (ex_rd != 0) &&
             ((de_uses_rs1 && de_rs1 == ex_rd) || (de_uses_rs2 && de_rs2 == ex_rd));
        chk({p, "_stall_cnt"}, (k == 0) ? 64'(sc_a) : 64'(sc_b), m_sc[k]);
        chk({p, "_flush_cnt"}, (k == 0) ? 64'(fc_a) : 64'(fc_b), m_fc[k]);
        if (mem_busy) begin
            {e_fe, e_de, e_pr} = 3'b000;
        end else if (br_taken) begin
            {e_fe, e_de, e_pr} = 3'b111;
            if (m_fc[k] < cmax[k]) m_fc[k]++;
            m_fl[k] = FLC - 1; m_sl[k] = 0;
        end else if (m_fl[k] > 0) begin
            {e_fe, e_de, e_pr} = 3'b111;
            if (m_fc[k] < cmax[k]) m_fc[k]++;
            m_fl[k]--;
        end else if (m_sl[k] > 0) begin
            {e_fe, e_de, e_pr} = 3'b011;
            if (m_sc[k] < cmax[k]) m_sc[k]++;
            m_sl[k]--;
        end else if (lu) begin
            {e_fe, e_de, e_pr} = 3'b011;
            if (m_sc[k] < cmax[k]) m_sc[k]++;
            m_sl[k] = lat[k] - 1;
        end else begin
            {e_fe, e_de, e_pr} = 3'b110;
        end
        chk({p, "_outs"}, (k == 0) ? {61'd0, fe_a, de_a, pr_a} : {61'd0, fe_b, de_b, pr_b},
            {61'd0, e_fe, e_de, e_pr});
    endtask

    task automatic tick();
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    in_t  IDLE, LU, BR;
    vec_t tbl[10];

    initial begin
        IDLE = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        LU   = mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0);
        BR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        tbl[0] = '{"no_dep",     mk(1, 3, 4, 1, 1, 1, 5, 1, 1, 0, 0), 1, 1, 0};
        tbl[1] = '{"x0_dep",     mk(1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0), 1, 1, 0};
        tbl[2] = '{"rs2_unused", mk(1, 1, 7, 0, 0, 1, 7, 1, 1, 0, 0), 1, 1, 0};
        tbl[3] = '{"rs2_hit",    mk(1, 1, 7, 0, 1, 1, 7, 1, 1, 0, 0), 0, 1, 1};
        tbl[4] = '{"not_load",   mk(1, 9, 0, 1, 0, 1, 9, 0, 1, 0, 0), 1, 1, 0};
        tbl[5] = '{"ex_invalid", mk(1, 9, 0, 1, 0, 0, 9, 1, 1, 0, 0), 1, 1, 0};
        tbl[6] = '{"de_invalid", mk(0, 9, 0, 1, 0, 1, 9, 1, 1, 0, 0), 1, 1, 0};
        tbl[7] = '{"no_wr",      mk(1, 9, 0, 1, 0, 1, 9, 1, 0, 0, 0), 1, 1, 0};
        tbl[8] = '{"rs1_hit",    mk(1, 9, 0, 1, 0, 1, 9, 1, 1, 0, 0), 0, 1, 1};
        tbl[9] = '{"rs1_unused", mk(1, 9, 0, 0, 0, 1, 9, 1, 1, 0, 0), 1, 1, 0};

        // reset state
        reset_n = 1'b0;
        drive(IDLE);
        model_reset();
        #1;
        chk("rst_outs_a", {fe_a, de_a, pr_a}, 3'b001);
        chk("rst_outs_b", {fe_b, de_b, pr_b}, 3'b001);
        chk("rst_cnt_a", {sc_a, fc_a}, 0);
        chk("rst_cnt_b", {sc_b, fc_b}, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        drive(IDLE);
        tick();

        // load-use, LOAD_LAT=1
        drive(LU);
        chk("lu_outs_a", {fe_a, de_a, pr_a}, 3'b011);
        tick();
        drive(IDLE);
        chk("lu_after_a", {fe_a, de_a, pr_a}, 3'b110);
        chk("lu_stall_a", sc_a, 1);
        tick();
        drive(IDLE);
        tick();

        // redirect during 2nd stall cycle, LOAD_LAT=3
        drive(LU);
        tick();
        drive(BR);
        chk("rds_outs_b", {fe_b, de_b, pr_b}, 3'b111);
        chk("rds_stall_b", sc_b, 4);
        tick();
        drive(IDLE);
        chk("rds_flush_b", {fe_b, pr_b}, 2'b11);
        tick();
        drive(IDLE);
        chk("rds_done_b", {fe_b, de_b, pr_b}, 3'b110);
        chk("rds_stall2_b", sc_b, 4);
        tick();

        // redirect window, FLUSH_CYCLES=2
        drive(BR);
        chk("br_c1_a", {fe_a, pr_a}, 2'b11);
        tick();
        drive(IDLE);
        chk("br_c2_a", {fe_a, pr_a}, 2'b11);
        tick();
        drive(IDLE);
        chk("br_c3_a", {fe_a, pr_a}, 2'b10);
        chk("br_fcnt_a", fc_a, 4);
        tick();
        drive(BR); tick();
        drive(BR); tick();
        drive(IDLE);
        chk("br2_c3_a", pr_a, 1);
        tick();
        drive(IDLE);
        chk("br2_c4_a", pr_a, 0);
        chk("br2_fcnt_a", fc_a, 7);
        tick();

        // priority: mem_busy over br_taken and lu_hit
        drive(mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 1, 1));
        chk("busy_outs_a", {fe_a, de_a, pr_a}, 3'b000);
        chk("busy_outs_b", {fe_b, de_b, pr_b}, 3'b000);
        tick();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        chk("busy_hold_a", {sc_a, fc_a}, {32'd2, 32'd7});
        tick();
        drive(BR);
        chk("busy_rel_a", {fe_a, de_a, pr_a}, 3'b111);
        tick();
        drive(IDLE);
        chk("busy_flush_a", {pr_a, 32'(fc_a)}, {1'b1, 32'd8});
        tick();
        drive(IDLE);
        tick();
        drive(IDLE);
        tick();

        // combinational hazard table (instance a, from RUN)
        foreach (tbl[i]) begin
            drive(tbl[i].in);
            chk({"tbl_", tbl[i].name}, {fe_a, de_a, pr_a}, {tbl[i].fe, tbl[i].de, tbl[i].pr});
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(IDLE);
            tick();
        end

        // reset in the middle of a flush
        drive(BR);
        tick();
        drive(IDLE);
        reset_n = 1'b0;
        #1;
        chk("rstf_outs_a", {fe_a, de_a, pr_a}, 3'b001);
        chk("rstf_cnt_a", {sc_a, fc_a}, 0);
        chk("rstf_cnt_b", {sc_b, fc_b}, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(IDLE);
        chk("rstf_run_a", {fe_a, de_a, pr_a}, 3'b110);
        chk("rstf_run_b", {fe_b, de_b, pr_b}, 3'b110);
        tick();

        // random traffic against the model (b saturates its 4-bit counters)
        for (int i = 0; i < 3000; i++) begin
            in_t v;
            v = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
            drive(v);
            tick();
        end
        chk("sat_stall_b", sc_b, 15);
        chk("sat_flush_b", fc_b, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
